nibble_mult_ctrl: RTL and testbench

Sequential control and accumulate stage for the 8x8 multiplier.
- Latches the two 8-bit operands and drives them onto the inputs of two nibble muxes, one for operand A and one for operand B.
- Steps the mux selects through all four nibble pairs and consumes the returned 4-bit nibbles.
- Forms each 4x4 partial product, shifts it into place and accumulates the 16-bit result.
- Uses a start/busy/done handshake toward the issuing logic.

---
 rtl/mult8_pkg.sv | 19 +
 rtl/nibble_mult_ctrl_mult_4x4.sv | 13 +
 rtl/nibble_mult_ctrl.sv | 111 +++++++++++
 tb/tb_nibble_mult_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mult8_pkg.sv
// Shared widths, FSM states and per-step shift table for the nibble-serial 8x8 multiplier.
package mult8_pkg;

  localparam int NIB   = 4;
  localparam int OP_W  = 2 * NIB;
  localparam int RES_W = 4 * NIB;
  localparam int STEPS = 4;
  localparam int CNT_W = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step k multiplies (A[cnt[1]], B[cnt[0]]); its weight is 4*(cnt[1]+cnt[0]).
  localparam logic [3:0] SHIFT_TBL [STEPS] = '{4'd0, 4'd4, 4'd4, 4'd8};

endpackage

// File: rtl/nibble_mult_ctrl_mult_4x4.sv
// Combinational unsigned NIBxNIB multiplier producing the full 2*NIB-bit partial product.
// Zero latency, no flow control.
module mult_4x4
  import mult8_pkg::*;
(
  input  logic [NIB-1:0]  a_i,
  input  logic [NIB-1:0]  b_i,
  output logic [OP_W-1:0] p_o
);

  assign p_o = OP_W'(a_i) * OP_W'(b_i);

endmodule

// File: rtl/nibble_mult_ctrl.sv
// Nibble-serial 8x8 multiply: latches operands, walks four mux select pairs, accumulates 16-bit product.
// Start accepted in IDLE/DONE, done pulses 5 cycles later; start is ignored while busy.
module nibble_mult_ctrl
  import mult8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  a_in,
  input  logic [OP_W-1:0]  b_in,
  output logic [OP_W-1:0]  op_a,
  output logic [OP_W-1:0]  op_b,
  output logic             sel_a,
  output logic             sel_b,
  input  logic [NIB-1:0]   nib_a,
  input  logic [NIB-1:0]   nib_b,
  output logic [RES_W-1:0] product,
  output logic             busy,
  output logic             done
);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RES_W-1:0]   acc_q;
  logic [OP_W-1:0]    op_a_q;
  logic [OP_W-1:0]    op_b_q;
  logic [RES_W-1:0]   prod_q;
  logic               sel_a_q;
  logic               sel_b_q;
  logic               busy_q;
  logic               done_q;

  logic [OP_W-1:0]    pp;
  logic [RES_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;

  mult_4x4 u_mult (
    .a_i (nib_a),
    .b_i (nib_b),
    .p_o (pp)
  );

  assign acc_d = acc_q + (RES_W'(pp) << SHIFT_TBL[cnt_q]);
  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      prod_q  <= '0;
      sel_a_q <= 1'b0;
      sel_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          sel_a_q <= 1'b0;
          sel_b_q <= 1'b0;
          if (start) begin
            op_a_q  <= a_in;
            op_b_q  <= b_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (cnt_q == CNT_W'(STEPS - 1)) begin
            prod_q  <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sel_a_q <= 1'b0;
            sel_b_q <= 1'b0;
            state_q <= DONE;
          end else begin
            // Selects lead the counter by one edge so they match cnt in the next cycle.
            sel_a_q <= cnt_d[1];
            sel_b_q <= cnt_d[0];
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          sel_a_q <= 1'b0;
          sel_b_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign sel_a   = sel_a_q;
  assign sel_b   = sel_b_q;
  assign product = prod_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_nibble_mult_ctrl.sv
// Directed bench for nibble_mult_ctrl with real nibble muxes and a cycle-level reference model.
module tb_nibble_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        sel_a;
  logic        sel_b;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign nib_a = sel_a ? op_a[7:4] : op_a[3:0];
  assign nib_b = sel_b ? op_b[7:4] : op_b[3:0];

  nibble_mult_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .op_a    (op_a),
    .op_b    (op_b),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .nib_a   (nib_a),
    .nib_b   (nib_b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = idle, 1..4 = multiply steps, 5 = result cycle.
  int          m_phase = 0;
  logic [7:0]  m_opa   = '0;
  logic [7:0]  m_opb   = '0;
  logic [15:0] m_prod  = '0;
  bit          m_valid = 1'b0;
  logic [1:0]  pair_seq [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
      m_opa   = '0;
      m_opb   = '0;
      m_prod  = '0;
      m_valid = 1'b1;
    end else if (m_phase == 0 || m_phase == 5) begin
      if (start) begin
        m_opa   = a_in;
        m_opb   = b_in;
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
    end else if (m_phase == 4) begin
      m_prod  = 16'(m_opa) * 16'(m_opb);
      m_phase = 5;
    end else begin
      m_phase = m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [1:0] exp_sel;
      exp_sel = (m_phase >= 1 && m_phase <= 4) ? pair_seq[m_phase-1] : 2'b00;
      chk("model op_a", 32'(op_a), 32'(m_opa));
      chk("model op_b", 32'(op_b), 32'(m_opb));
      chk("model product", 32'(product), 32'(m_prod));
      chk("model busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 4));
      chk("model done", 32'(done), 32'(m_phase == 5));
      chk("model sel", 32'({sel_a, sel_b}), 32'(exp_sel));
    end
  end

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
  endtask

  // Follows one accepted op through cycles T+1..T+5; optionally pulses a stray start at step pulse_k.
  task automatic await_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                          input logic [15:0] prev_p, input int pulse_k);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        chk("lit busy", 32'(busy), 32'd1);
        chk("lit done early", 32'(done), 32'd0);
        chk("lit sel pair", 32'({sel_a, sel_b}), 32'(k - 1));
        chk("lit product hold", 32'(product), 32'(prev_p));
      end else begin
        chk("lit done", 32'(done), 32'd1);
        chk("lit busy at done", 32'(busy), 32'd0);
        chk("lit product", 32'(product), 32'(exp_p));
      end
      chk("lit op_a", 32'(op_a), 32'(a));
      chk("lit op_b", 32'(op_b), 32'(b));
      if (k == pulse_k) begin
        start = 1'b1;
        a_in  = 8'h77;
        b_in  = 8'h77;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    chk("reset product", 32'(product), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sel", 32'({sel_a, sel_b}), 32'd0);
    chk("reset op_a", 32'(op_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    launch(8'h12, 8'h34);
    await_op(8'h12, 8'h34, 16'h03A8, 16'h0000, 0);
    @(negedge clk);
    launch(8'hFF, 8'hFF);
    await_op(8'hFF, 8'hFF, 16'hFE01, 16'h03A8, 0);
    @(negedge clk);
    launch(8'h00, 8'hA5);
    await_op(8'h00, 8'hA5, 16'h0000, 16'hFE01, 0);
    repeat (3) @(negedge clk);
    chk("idle product hold", 32'(product), 32'h0000);
    launch(8'h01, 8'hA5);
    await_op(8'h01, 8'hA5, 16'h00A5, 16'h0000, 0);
    @(negedge clk);

    launch(8'h0F, 8'h10);
    await_op(8'h0F, 8'h10, 16'h00F0, 16'h00A5, 2);
    launch(8'h03, 8'h05);
    await_op(8'h03, 8'h05, 16'h000F, 16'h00F0, 0);
    repeat (2) @(negedge clk);

    launch(8'h55, 8'h33);
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-reset busy", 32'(busy), 32'd1);
    chk("pre-reset sel at cnt2", 32'({sel_a, sel_b}), 32'b10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset product", 32'(product), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset sel", 32'({sel_a, sel_b}), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no done after reset", 32'(done), 32'd0);
    end
    launch(8'h20, 8'h08);
    await_op(8'h20, 8'h08, 16'h0100, 16'h0000, 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
